// File: rtl/instr_fetch.sv
// Instruction fetch stage and IF/ID register: holds the PC, runs the request/ready read
// handshake with instruction memory, and applies stalls, flushes and branch redirects.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] Instr,
  output logic [31:0] PCPlus4,
  output logic        instr_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_req_addr, w_req_addr_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pcp4, w_pcp4_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_skid_instr, w_skid_instr_nxt;
  logic [31:0] r_skid_pc, w_skid_pc_nxt;
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;

  assign w_target = branch_target & ~32'd3;
  assign w_pc_inc = r_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_instr      <= 32'd0;
      r_pcp4       <= 32'd0;
      r_valid      <= 1'b0;
      r_skid_instr <= 32'd0;
      r_skid_pc    <= 32'd0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_instr      <= w_instr_nxt;
      r_pcp4       <= w_pcp4_nxt;
      r_valid      <= w_valid_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_req_addr_nxt   = r_req_addr;
    w_instr_nxt      = r_instr;
    w_pcp4_nxt       = r_pcp4;
    w_valid_nxt      = r_valid;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc_nxt    = r_skid_pc;
    imem_req         = 1'b0;
    imem_addr        = r_pc;
    case (r_state)
      IDLE: w_state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (branch_taken || flush) begin
          // A redirect mid-request keeps the old request alive in DISCARD until it completes.
          if (branch_taken) w_pc_nxt = w_target;
          w_instr_nxt = 32'd0;
          w_pcp4_nxt  = 32'd0;
          w_valid_nxt = 1'b0;
          if (!imem_ready) begin
            w_req_addr_nxt = r_pc;
            w_state_nxt    = DISCARD;
          end
        end else if (imem_ready) begin
          w_pc_nxt = w_pc_inc;
          if (stall && r_valid) begin
            w_skid_instr_nxt = imem_rdata;
            w_skid_pc_nxt    = r_pc;
            w_state_nxt      = HOLD;
          end else begin
            w_instr_nxt = imem_rdata;
            w_pcp4_nxt  = w_pc_inc;
            w_valid_nxt = 1'b1;
          end
        end else if (!stall) begin
          w_valid_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (branch_taken || flush) begin
          w_pc_nxt    = branch_taken ? w_target : r_skid_pc;
          w_instr_nxt = 32'd0;
          w_pcp4_nxt  = 32'd0;
          w_valid_nxt = 1'b0;
          w_state_nxt = FETCH;
        end else if (!stall) begin
          w_instr_nxt = r_skid_instr;
          w_pcp4_nxt  = r_skid_pc + 32'd4;
          w_valid_nxt = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = r_req_addr;
        if (branch_taken) w_pc_nxt = w_target;
        if (imem_ready)   w_state_nxt = FETCH;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign Instr       = r_instr;
  assign PCPlus4     = r_pcp4;
  assign instr_valid = r_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic checked against an
// instruction-stream scoreboard (every word leaving IF/ID must be the next expected address).
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready, stall, flush, branch_taken, instr_valid;
  logic [31:0] imem_addr, imem_rdata, branch_target, Instr, PCPlus4;

  logic        req2, ready2, valid2, zero2;
  logic [31:0] addr2, rdata2, tgt2, Instr2, PCPlus4_2;

  assign ready2 = 1'b1;
  assign zero2  = 1'b0;
  assign tgt2   = 32'd0;
  assign rdata2 = addr2 + 32'h1000;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target), .Instr(Instr),
    .PCPlus4(PCPlus4), .instr_valid(instr_valid)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
    .imem_ready(ready2), .imem_rdata(rdata2), .stall(zero2), .flush(zero2),
    .branch_taken(zero2), .branch_target(tgt2), .Instr(Instr2),
    .PCPlus4(PCPlus4_2), .instr_valid(valid2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_deliv = 0;
  int mem_wait = 0;
  int wcnt = 0;
  bit busy = 1'b0;
  logic [31:0] nxt;

  bit          p_ok;
  logic        p_req, p_ready, p_stall, p_flush, p_br, p_valid;
  logic [31:0] p_addr, p_tgt, p_instr, p_pcp4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Negedge: check what the last edge did, then answer memory and default the controls.
  task automatic tick_begin();
    @(negedge clk);
    if (p_ok) begin
      if (p_req && !p_ready) begin
        chk("req_held", 32'(imem_req), 32'd1);
        chk("addr_stable", imem_addr, p_addr);
      end else if (p_br) begin
        chk("redir_addr", imem_addr, p_tgt & ~32'd3);
        chk("redir_req", 32'(imem_req), 32'd1);
      end
      if (p_br || p_flush) begin
        chk("clr_valid", 32'(instr_valid), 32'd0);
        chk("clr_instr", Instr, 32'd0);
      end else if (p_stall && p_valid) begin
        chk("stall_instr", Instr, p_instr);
        chk("stall_pcp4", PCPlus4, p_pcp4);
        chk("stall_valid", 32'(instr_valid), 32'd1);
      end
    end
    if (imem_req) begin
      if (!busy) begin
        busy = 1'b1;
        wcnt = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
      end
      imem_ready = (wcnt == 0);
      if (imem_ready) busy = 1'b0;
      else            wcnt--;
      imem_rdata = imem_ready ? imem_addr + 32'h1000 : $urandom;
    end else begin
      busy       = 1'b0;
      imem_ready = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end
    stall         = 1'b0;
    flush         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = $urandom;
  endtask

  // Scoreboard: a word leaves IF/ID when consumed or squashed; a branch re-aims the stream.
  task automatic tick_end();
    if (instr_valid && (!stall || flush || branch_taken)) begin
      chk("leave_instr", Instr, nxt + 32'h1000);
      chk("leave_pcp4", PCPlus4, nxt + 32'd4);
      nxt = nxt + 32'd4;
      n_deliv++;
    end
    if (branch_taken) nxt = branch_target & ~32'd3;
    p_ok    = 1'b1;
    p_req   = imem_req;
    p_ready = imem_ready;
    p_addr  = imem_addr;
    p_stall = stall;
    p_flush = flush;
    p_br    = branch_taken;
    p_tgt   = branch_target;
    p_valid = instr_valid;
    p_instr = Instr;
    p_pcp4  = PCPlus4;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_instr"}, Instr, 32'd0);
    chk({tag, "_pcp4"}, PCPlus4, 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    imem_ready = 1'b0; imem_rdata = 32'd0;
    p_ok = 1'b0; busy = 1'b0; nxt = 32'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // Zero-wait memory: one word per cycle, plus wrap-around on the second instance.
    mem_wait = 0;
    do_reset();
    chk("wrap_rst_addr", addr2, 32'hFFFF_FFFC);
    chk("wrap_rst_req", 32'(req2), 32'd0);
    tick_begin();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    tick_end();
    for (int i = 0; i < 8; i++) begin
      tick_begin();
      chk("zw_addr", imem_addr, 32'(4 * (i + 1)));
      chk("zw_valid", 32'(instr_valid), 32'd1);
      chk("zw_instr", Instr, 32'h1000 + 32'(4 * i));
      chk("zw_pcp4", PCPlus4, 32'(4 * i + 4));
      if (i == 0) begin
        chk("wrap_second_addr", addr2, 32'd0);
        chk("wrap_instr", Instr2, 32'h0000_0FFC);
        chk("wrap_pcp4", PCPlus4_2, 32'd0);
      end
      tick_end();
    end

    // Two-wait memory: instr_valid pulses one cycle after each accepted response.
    mem_wait = 2;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick_begin();
      if (p_ok) chk("wait2_pulse", 32'(instr_valid), 32'(p_req && p_ready));
      tick_end();
    end

    // Three-cycle stall while the word at 8 returns.
    mem_wait = 0;
    do_reset();
    tick_begin(); tick_end();
    tick_begin(); tick_end();
    for (int i = 0; i < 4; i++) begin
      tick_begin();
      chk("stall_hold_instr", Instr, 32'h1004);
      if (i > 0) chk("hold_no_req", 32'(imem_req), 32'd0);
      else       chk("stall_addr", imem_addr, 32'd8);
      stall = (i < 3);
      tick_end();
    end
    tick_begin(); chk("after_stall_0", Instr, 32'h1008); tick_end();
    tick_begin(); chk("after_stall_1", Instr, 32'h100C); tick_end();

    // Branch to an unaligned target while the request to 0xC waits.
    mem_wait = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick_begin();
      if (imem_req && !imem_ready && imem_addr == 32'hC) begin
        found = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0043;
      end
      tick_end();
    end
    chk("br_setup", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick_begin();
      if (imem_req && imem_addr == 32'h40) found = 1'b1;
      chk("br_gap_valid", 32'(instr_valid), 32'd0);
      tick_end();
    end
    chk("br_reach_target", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick_begin();
      if (instr_valid) begin
        found = 1'b1;
        chk("br_instr", Instr, 32'h1040);
      end
      tick_end();
    end
    chk("br_deliver", 32'(found), 32'd1);

    // Flush alone with PC at 0x10: the word is refetched.
    mem_wait = 0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick_begin();
      if (imem_req && imem_addr == 32'h10) begin
        found = 1'b1;
        flush = 1'b1;
      end
      tick_end();
    end
    chk("fl_setup", 32'(found), 32'd1);
    tick_begin();
    chk("fl_valid", 32'(instr_valid), 32'd0);
    chk("fl_instr", Instr, 32'd0);
    chk("fl_refetch", imem_addr, 32'h10);
    tick_end();
    tick_begin();
    chk("fl_instr_after", Instr, 32'h1010);
    chk("fl_valid_after", 32'(instr_valid), 32'd1);
    tick_end();

    // Asynchronous reset in the middle of a waiting request.
    mem_wait = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick_begin();
      if (instr_valid && imem_req && !imem_ready) found = 1'b1;
      tick_end();
    end
    chk("mid_setup", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    chk("mid_rst_wrap_addr", addr2, 32'hFFFF_FFFC);

    // Randomized traffic: variable waits, stalls, flushes and branches.
    mem_wait = -1;
    do_reset();
    n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      tick_begin();
      stall        = ($urandom_range(0, 99) < 30);
      flush        = ($urandom_range(0, 99) < 6);
      branch_taken = ($urandom_range(0, 99) < 6);
      tick_end();
    end
    chk("rand_progress", 32'(n_deliv > 50), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
